// File: rtl/pipe_sequencer.sv
// pipe_sequencer
// Host-facing sequencer for a 5-stage pipeline. It accepts host commands
// (LOAD a register, RUN, single STEP, HALT/pause), generates the fetch and
// pipeline-advance enables, freezes fetch when the halt instruction reaches
// IF/ID, drains the back end for a fixed number of cycles, and then parks in
// HALTED until reset.
//
// Ports
//   i_clk         clock, rising-edge active
//   i_rst         asynchronous reset, active low
//   i_cmd_valid   host command valid
//   o_cmd_ready   sequencer can take a command this cycle
//   i_cmd_op      00 LOAD, 01 RUN, 10 STEP, 11 HALT
//   i_cmd_reg     LOAD target register
//   i_cmd_data    LOAD data
//   i_instr       instruction currently in IF/ID
//   o_pc_we       PC write enable
//   o_if_id_we    IF/ID latch write enable
//   o_pipe_en     advance enable for ID/EX, EX/MEM, MEM/WB
//   o_wb_rf_webn  register-file write strobe (1 = write)
//   o_wb_data     register-file write data
//   o_reg_dst     register-file write address
//   o_cycle_cnt   saturating count of cycles with o_pipe_en = 1
//   o_state       IDLE=0 LOAD=1 RUN=2 STEP=3 DRAIN=4 HALTED=5
//   o_halted      halt reached and pipeline drained
module pipe_sequencer #(
  parameter int                 NB_BITS      = 32,
  parameter int                 NB_REG       = 5,
  parameter int                 NB_CNT       = 32,
  parameter int                 DRAIN_CYCLES = 4,
  parameter logic [NB_BITS-1:0] HALT_WORD    = {NB_BITS{1'b1}}
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_op,
  input  logic [NB_REG-1:0]  i_cmd_reg,
  input  logic [NB_BITS-1:0] i_cmd_data,
  input  logic [NB_BITS-1:0] i_instr,
  output logic               o_pc_we,
  output logic               o_if_id_we,
  output logic               o_pipe_en,
  output logic               o_wb_rf_webn,
  output logic [NB_BITS-1:0] o_wb_data,
  output logic [NB_REG-1:0]  o_reg_dst,
  output logic [NB_CNT-1:0]  o_cycle_cnt,
  output logic [2:0]         o_state,
  output logic               o_halted
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [3:0] LAST_FROZEN = 4'(DRAIN_CYCLES);

  state_t             state;
  state_t             state_next;
  logic [3:0]         drain_cnt;
  logic [3:0]         drain_cnt_next;
  logic               load_to_halted;
  logic               load_to_halted_next;
  logic               capture;
  logic [NB_BITS-1:0] wb_data;
  logic [NB_REG-1:0]  reg_dst;
  logic [NB_CNT-1:0]  cycle_cnt;
  logic               cmd_ready;
  logic               accept;
  logic               halt_seen;
  logic               pc_we;
  logic               if_id_we;
  logic               pipe_en;
  logic               wb_we;
  logic               halted;

  // Ready is gated by reset directly so it reads 0 while reset is held,
  // even though the state register already shows IDLE.
  assign cmd_ready = i_rst && ((state == ST_IDLE) || (state == ST_RUN) ||
                               (state == ST_HALTED));
  assign accept    = i_cmd_valid && cmd_ready;
  assign halt_seen = (i_instr == HALT_WORD);

  // State register, LOAD capture registers and the saturating cycle counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= ST_IDLE;
      drain_cnt      <= 4'd0;
      load_to_halted <= 1'b0;
      wb_data        <= '0;
      reg_dst        <= '0;
      cycle_cnt      <= '0;
    end else begin
      state          <= state_next;
      drain_cnt      <= drain_cnt_next;
      load_to_halted <= load_to_halted_next;
      if (capture) begin
        wb_data <= i_cmd_data;
        reg_dst <= i_cmd_reg;
      end
      if (pipe_en && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + NB_CNT'(1);
      end
    end
  end

  // Next-state and enable generation. The halt word gates fetch off in the
  // same cycle it is seen and wins over a HALT command arriving alongside it.
  // drain_cnt holds the number of frozen cycles already completed, the
  // detection cycle being the first.
  always_comb begin
    state_next          = state;
    drain_cnt_next      = drain_cnt;
    load_to_halted_next = load_to_halted;
    capture             = 1'b0;
    pc_we               = 1'b0;
    if_id_we            = 1'b0;
    pipe_en             = 1'b0;
    wb_we               = 1'b0;
    halted              = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (i_cmd_op)
            OP_LOAD: begin
              capture             = 1'b1;
              load_to_halted_next = 1'b0;
              state_next          = ST_LOAD;
            end
            OP_RUN:  state_next = ST_RUN;
            OP_STEP: state_next = ST_STEP;
            default: state_next = ST_IDLE;
          endcase
        end
      end

      ST_LOAD: begin
        wb_we      = (reg_dst != '0);
        state_next = load_to_halted ? ST_HALTED : ST_IDLE;
      end

      ST_RUN, ST_STEP: begin
        pipe_en = 1'b1;
        if (halt_seen) begin
          drain_cnt_next = 4'd1;
          state_next     = (DRAIN_CYCLES == 1) ? ST_HALTED : ST_DRAIN;
        end else begin
          pc_we    = 1'b1;
          if_id_we = 1'b1;
          if (state == ST_STEP) begin
            state_next = ST_IDLE;
          end else if (accept && (i_cmd_op == OP_HALT)) begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        pipe_en        = 1'b1;
        drain_cnt_next = drain_cnt + 4'd1;
        if (drain_cnt_next == LAST_FROZEN) begin
          state_next = ST_HALTED;
        end
      end

      ST_HALTED: begin
        halted = 1'b1;
        if (accept && (i_cmd_op == OP_LOAD)) begin
          capture             = 1'b1;
          load_to_halted_next = 1'b1;
          state_next          = ST_LOAD;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign o_cmd_ready  = cmd_ready;
  assign o_pc_we      = pc_we;
  assign o_if_id_we   = if_id_we;
  assign o_pipe_en    = pipe_en;
  assign o_wb_rf_webn = wb_we;
  assign o_wb_data    = wb_data;
  assign o_reg_dst    = reg_dst;
  assign o_cycle_cnt  = cycle_cnt;
  assign o_state      = state;
  assign o_halted     = halted;

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer
// Drives pipe_sequencer with directed command sequences and random traffic.
// A behavioural model of the sequencer rules produces the expected outputs
// for every cycle; a second instance with a 4-bit cycle counter exercises
// counter saturation.
module tb_pipe_sequencer;

  localparam int          DRAIN     = 4;
  localparam logic [31:0] HALT_WORD = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_reg = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [31:0] instr = 32'd0;

  logic        cmd_ready, pc_we, if_id_we, pipe_en, wb_rf_webn, halted;
  logic [31:0] wb_data;
  logic [4:0]  reg_dst;
  logic [31:0] cycle_cnt;
  logic [2:0]  state;

  logic        s_cmd_ready, s_pc_we, s_if_id_we, s_pipe_en, s_wb_rf_webn, s_halted;
  logic [31:0] s_wb_data;
  logic [4:0]  s_reg_dst;
  logic [3:0]  s_cycle_cnt;
  logic [2:0]  s_state;

  pipe_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_reg(cmd_reg), .i_cmd_data(cmd_data), .i_instr(instr),
    .o_pc_we(pc_we), .o_if_id_we(if_id_we), .o_pipe_en(pipe_en),
    .o_wb_rf_webn(wb_rf_webn), .o_wb_data(wb_data), .o_reg_dst(reg_dst),
    .o_cycle_cnt(cycle_cnt), .o_state(state), .o_halted(halted)
  );

  pipe_sequencer #(.NB_CNT(4), .DRAIN_CYCLES(DRAIN)) dut_small (
    .i_clk(clk), .i_rst(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(s_cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_reg(cmd_reg), .i_cmd_data(cmd_data), .i_instr(instr),
    .o_pc_we(s_pc_we), .o_if_id_we(s_if_id_we), .o_pipe_en(s_pipe_en),
    .o_wb_rf_webn(s_wb_rf_webn), .o_wb_data(s_wb_data), .o_reg_dst(s_reg_dst),
    .o_cycle_cnt(s_cycle_cnt), .o_state(s_state), .o_halted(s_halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;

  // model state: mode uses the published state numbers
  int          m_mode, p_mode;
  int          m_frozen, p_frozen;
  bit          m_ret, p_ret;
  logic [31:0] m_data, p_data;
  logic [4:0]  m_dst, p_dst;
  longint      m_cnt, p_cnt;

  // last observed DUT values, for directed literal checks
  logic        obs_ready, obs_pc_we, obs_if_id_we, obs_pipe_en, obs_webn, obs_halted;
  logic [31:0] obs_wb_data, obs_cnt;
  logic [4:0]  obs_dst;
  logic [2:0]  obs_state;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_mode = 0; m_frozen = 0; m_ret = 1'b0; m_data = 32'd0; m_dst = 5'd0; m_cnt = 0;
  endtask

  // Compute this cycle's expected outputs from the model and the current
  // inputs, compare both instances, and prepare the model's next values.
  task automatic checkOutput();
    bit rdy, acc, hw, e_pc, e_if, e_pipe, e_webn, e_halt;
    longint small_cnt;
    rdy = rst_n && (m_mode == 0 || m_mode == 2 || m_mode == 5);
    acc = cmd_valid && rdy;
    hw = (instr == HALT_WORD);
    e_pc = 0; e_if = 0; e_pipe = 0; e_webn = 0; e_halt = 0;
    p_mode = m_mode; p_frozen = m_frozen; p_ret = m_ret; p_data = m_data; p_dst = m_dst;
    case (m_mode)
      0: if (acc) begin
           if (cmd_op == 2'b00) begin
             p_mode = 1; p_ret = 1'b0; p_data = cmd_data; p_dst = cmd_reg;
           end else if (cmd_op == 2'b01) p_mode = 2;
           else if (cmd_op == 2'b10) p_mode = 3;
         end
      1: begin e_webn = (m_dst != 0); p_mode = m_ret ? 5 : 0; end
      2, 3: begin
        e_pipe = 1;
        if (hw) begin
          p_frozen = 1; p_mode = (DRAIN == 1) ? 5 : 4;
        end else begin
          e_pc = 1; e_if = 1;
          if (m_mode == 3) p_mode = 0;
          else if (acc && cmd_op == 2'b11) p_mode = 0;
        end
      end
      4: begin
        e_pipe = 1; p_frozen = m_frozen + 1;
        if (p_frozen == DRAIN) p_mode = 5;
      end
      5: begin
        e_halt = 1;
        if (acc && cmd_op == 2'b00) begin
          p_mode = 1; p_ret = 1'b1; p_data = cmd_data; p_dst = cmd_reg;
        end
      end
      default: ;
    endcase
    p_cnt = m_cnt + (e_pipe ? 1 : 0);
    if (p_cnt > 64'hFFFFFFFF) p_cnt = 64'hFFFFFFFF;
    small_cnt = (m_cnt > 15) ? 15 : m_cnt;

    checkValue("state", {29'd0, state}, m_mode);
    checkValue("cmd_ready", {31'd0, cmd_ready}, {31'd0, rdy});
    checkValue("pc_we", {31'd0, pc_we}, {31'd0, e_pc});
    checkValue("if_id_we", {31'd0, if_id_we}, {31'd0, e_if});
    checkValue("pipe_en", {31'd0, pipe_en}, {31'd0, e_pipe});
    checkValue("wb_rf_webn", {31'd0, wb_rf_webn}, {31'd0, e_webn});
    checkValue("halted", {31'd0, halted}, {31'd0, e_halt});
    checkValue("wb_data", wb_data, m_data);
    checkValue("reg_dst", {27'd0, reg_dst}, {27'd0, m_dst});
    checkValue("cycle_cnt", cycle_cnt, m_cnt[31:0]);
    checkValue("small_flags", {26'd0, s_cmd_ready, s_pc_we, s_if_id_we, s_pipe_en, s_wb_rf_webn, s_halted},
               {26'd0, rdy, e_pc, e_if, e_pipe, e_webn, e_halt});
    checkValue("small_state", {29'd0, s_state}, m_mode);
    checkValue("small_wb", s_wb_data ^ {27'd0, s_reg_dst}, m_data ^ {27'd0, m_dst});
    checkValue("small_cnt_sat", {28'd0, s_cycle_cnt}, small_cnt[31:0]);

    obs_ready = cmd_ready; obs_pc_we = pc_we; obs_if_id_we = if_id_we; obs_pipe_en = pipe_en;
    obs_webn = wb_rf_webn; obs_halted = halted; obs_wb_data = wb_data; obs_cnt = cycle_cnt;
    obs_dst = reg_dst; obs_state = state;
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle,
  // then let the model follow the edge.
  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [4:0] r,
                               input logic [31:0] d, input logic [31:0] ins);
    cmd_valid = v; cmd_op = op; cmd_reg = r; cmd_data = d; instr = ins;
    #2;
    checkOutput();
    @(posedge clk);
    if (rst_n) begin
      m_mode = p_mode; m_frozen = p_frozen; m_ret = p_ret;
      m_data = p_data; m_dst = p_dst; m_cnt = p_cnt;
    end
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    applyStimulus(0, 2'b00, 5'd0, 32'd0, 32'd0);
    applyStimulus(1, 2'b01, 5'd3, 32'd7, HALT_WORD);
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 5'd0, 32'd0, 32'd0);
    checkValue("rst_release_ready", {31'd0, obs_ready}, 32'd1);
    checkValue("rst_release_state", {29'd0, obs_state}, 32'd0);
  endtask

  function automatic logic [31:0] plainInstr();
    return $urandom & 32'h7FFFFFFF;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0]  lregs[4];
    logic [31:0] ldata[4];
    int          strobe_at[4];
    logic [31:0] sdata[4];
    logic [4:0]  sdst[4];
    int          k, cyc, n_strobe, n_en, n_frozen;

    modelReset();
    #1;
    // reset held from time zero
    applyStimulus(1, 2'b01, 5'd0, 32'd0, 32'd0);
    checkValue("reset_ready", {31'd0, obs_ready}, 32'd0);
    checkValue("reset_cnt", obs_cnt, 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 5'd0, 32'd0, 32'd0);
    checkValue("first_ready", {31'd0, obs_ready}, 32'd1);

    // four back-to-back loads
    lregs = '{5'd1, 5'd2, 5'd21, 5'd20};
    ldata = '{32'd1, 32'd2, 32'd48, 32'd58};
    for (int i = 0; i < 4; i++) begin
      strobe_at[i] = -1; sdata[i] = 32'd0; sdst[i] = 5'd0;
    end
    k = 0; cyc = 0; n_strobe = 0;
    while (cyc < 20 && (k < 4 || n_strobe < 4)) begin
      if (k < 4) applyStimulus(1, 2'b00, lregs[k], ldata[k], 32'd0);
      else applyStimulus(0, 2'b00, 5'd0, 32'd0, 32'd0);
      if (obs_webn && n_strobe < 4) begin
        strobe_at[n_strobe] = cyc; sdata[n_strobe] = obs_wb_data; sdst[n_strobe] = obs_dst;
        n_strobe++;
      end
      if (k < 4 && obs_ready) k++;
      cyc++;
    end
    checkValue("load_strobe_count", n_strobe, 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkValue("load_strobe_cycle", strobe_at[i], 2 * i + 1);
      checkValue("load_data", sdata[i], ldata[i]);
      checkValue("load_dst", {27'd0, sdst[i]}, {27'd0, lregs[i]});
    end

    // load to register 0
    applyStimulus(1, 2'b00, 5'd0, 32'd5, 32'd0);
    checkValue("r0_state_a", {29'd0, obs_state}, 32'd0);
    applyStimulus(0, 2'b00, 5'd0, 32'd0, 32'd0);
    checkValue("r0_state_b", {29'd0, obs_state}, 32'd1);
    checkValue("r0_webn", {31'd0, obs_webn}, 32'd0);
    checkValue("r0_data", obs_wb_data, 32'd5);
    applyStimulus(0, 2'b00, 5'd0, 32'd0, 32'd0);
    checkValue("r0_state_c", {29'd0, obs_state}, 32'd0);

    // three single steps
    n_en = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b10, 5'd0, 32'd0, plainInstr());
      if (obs_pipe_en) n_en++;
      applyStimulus(0, 2'b00, 5'd0, 32'd0, plainInstr());
      if (obs_pipe_en) n_en++;
    end
    applyStimulus(0, 2'b00, 5'd0, 32'd0, 32'd0);
    checkValue("step_enabled_cycles", n_en, 32'd3);
    checkValue("step_cnt", obs_cnt, 32'd3);
    checkValue("step_state", {29'd0, obs_state}, 32'd0);

    // run with halt word on the 10th run cycle
    doReset();
    applyStimulus(1, 2'b01, 5'd0, 32'd0, plainInstr());
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 2'b00, 5'd0, 32'd0, (i == 10) ? HALT_WORD : plainInstr());
    end
    checkValue("halt_pc_we", {31'd0, obs_pc_we}, 32'd0);
    checkValue("halt_if_id_we", {31'd0, obs_if_id_we}, 32'd0);
    checkValue("halt_pipe_en", {31'd0, obs_pipe_en}, 32'd1);
    n_frozen = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 2), 2'b01, 5'd0, 32'd0, plainInstr());
      if (obs_pipe_en && !obs_pc_we) n_frozen++;
    end
    checkValue("drain_frozen_cycles", n_frozen, 32'd4);
    checkValue("halted_flag", {31'd0, obs_halted}, 32'd1);
    checkValue("halted_state", {29'd0, obs_state}, 32'd5);
    checkValue("halted_cnt", obs_cnt, 32'd13);

    // HALT command together with halt word
    doReset();
    applyStimulus(1, 2'b01, 5'd0, 32'd0, plainInstr());
    applyStimulus(0, 2'b00, 5'd0, 32'd0, plainInstr());
    applyStimulus(0, 2'b00, 5'd0, 32'd0, plainInstr());
    applyStimulus(1, 2'b11, 5'd0, 32'd0, HALT_WORD);
    applyStimulus(0, 2'b00, 5'd0, 32'd0, plainInstr());
    checkValue("halt_prio_state", {29'd0, obs_state}, 32'd4);

    // asynchronous reset in the middle of a drain cycle
    cmd_valid = 1'b0; instr = plainInstr();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkValue("async_state", {29'd0, obs_state}, 32'd0);
    checkValue("async_cnt", obs_cnt, 32'd0);
    checkValue("async_pipe_en", {31'd0, obs_pipe_en}, 32'd0);
    checkValue("async_ready", {31'd0, obs_ready}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 2'b00, 5'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 5'd0, 32'd0, 32'd0);
    checkValue("async_release_state", {29'd0, obs_state}, 32'd0);

    // random traffic, reset between segments
    for (int seg = 0; seg < 20; seg++) begin
      doReset();
      for (int c = 0; c < 60; c++) begin
        applyStimulus($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 31)), $urandom,
                      ($urandom_range(0, 15) == 0) ? HALT_WORD : plainInstr());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter NB_BITS, default 32, meaning data/instruction width.
REQ-002 SHALL have parameter NB_REG, default 5, meaning register-number width.
REQ-003 SHALL have parameter NB_CNT, default 32, meaning cycle-counter width.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 4, meaning frozen-fetch cycles after halt detection (range 1..15).
REQ-005 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning halt instruction encoding.
REQ-006 i_clk  input  1  clock; all state changes on its rising edge.
REQ-007 i_rst  input  1  reset, asynchronous, active-low.
REQ-008 i_cmd_valid  input  1  host command valid.
REQ-009 o_cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-010 i_cmd_op  input  2  command: 00 LOAD, 01 RUN, 10 STEP, 11 HALT.
REQ-011 i_cmd_reg  input  NB_REG  LOAD target register.
REQ-012 i_cmd_data  input  NB_BITS  LOAD data.
REQ-013 i_instr  input  NB_BITS  current IF/ID instruction.
REQ-014 o_pc_we  output  1  PC write enable to fetch stage.
REQ-015 o_if_id_we  output  1  IF/ID latch write enable.
REQ-016 o_pipe_en  output  1  advance enable for ID/EX, EX/MEM, MEM/WB latches.
REQ-017 o_wb_rf_webn  output  1  register-file write strobe, 1 = write.
REQ-018 o_wb_data  output  NB_BITS  register-file write data.
REQ-019 o_reg_dst  output  NB_REG  register-file write address.
REQ-020 o_cycle_cnt  output  NB_CNT  count of cycles with o_pipe_en=1.
REQ-021 o_state  output  3  state: IDLE=0, LOAD=1, RUN=2, STEP=3, DRAIN=4, HALTED=5.
REQ-022 o_halted  output  1  program reached halt and pipeline drained.

Function
REQ-023 Command SHALL be accepted exactly on a cycle with i_cmd_valid=1 and o_cmd_ready=1.
REQ-024 o_cmd_ready SHALL be 1 in IDLE, RUN and HALTED, 0 in LOAD, STEP and DRAIN.
REQ-025 IDLE: accepted LOAD -> LOAD, RUN -> RUN, STEP -> STEP; HALT is consumed with no effect.
REQ-026 LOAD SHALL last exactly one cycle: o_wb_rf_webn=1 with o_wb_data/o_reg_dst equal to the values registered at acceptance; then IDLE.
REQ-027 LOAD to register 0 SHALL keep o_wb_rf_webn=0 and still last one cycle.
REQ-028 o_wb_data and o_reg_dst SHALL hold their last loaded values outside LOAD.
REQ-029 RUN: o_pc_we=o_if_id_we=o_pipe_en=1 every cycle until exit.
REQ-030 RUN: accepted HALT -> that cycle remains fully enabled, next state IDLE (pause); LOAD/RUN/STEP accepted and dropped.
REQ-031 STEP: exactly one fully enabled cycle, then IDLE.
REQ-032 In RUN or STEP, if i_instr==HALT_WORD: o_pc_we=o_if_id_we=0, o_pipe_en=1 that cycle (combinational gating), next state DRAIN; this cycle is drain cycle 1.
REQ-033 Halt word SHALL take priority over a simultaneous accepted HALT command.
REQ-034 DRAIN: o_pc_we=o_if_id_we=0, o_pipe_en=1; after DRAIN_CYCLES total frozen cycles (including detection cycle) -> HALTED; DRAIN_CYCLES=1 goes RUN/STEP -> HALTED directly.
REQ-035 HALTED: all enables 0, o_halted=1; LOAD serviced as in IDLE (returns to HALTED); RUN/STEP/HALT consumed with no effect; exit only via reset.
REQ-036 IDLE, LOAD, HALTED: o_pc_we=o_if_id_we=o_pipe_en=0.
REQ-037 o_cycle_cnt SHALL increment by 1 on every cycle with o_pipe_en=1, saturating at all ones.

Reset
REQ-038 While i_rst=0: state IDLE, o_cycle_cnt=0, o_wb_data=0, o_reg_dst=0, all 1-bit outputs 0 including o_cmd_ready, effective immediately regardless of clock.
REQ-039 Reset asserted mid-LOAD, RUN or DRAIN SHALL abort the operation with no further write strobe or enable.
REQ-040 First rising edge after i_rst rises SHALL see o_cmd_ready=1 in IDLE.

Verification
REQ-041 LOAD r1=1, r2=2, r21=48, r20=58 back-to-back -> four single-cycle strobes, 1-cycle gap each (ready=0 in LOAD), correct data/address.
REQ-042 LOAD r0=5 -> o_wb_rf_webn stays 0, state 0->1->0.
REQ-043 STEP x3 from IDLE -> three single enabled cycles, o_cycle_cnt=3, o_state back to 0.
REQ-044 RUN, HALT_WORD on i_instr at 10th run cycle -> pc/if_id_we drop that cycle, 4 frozen pipe_en cycles, o_halted=1, o_cycle_cnt=13.
REQ-045 RUN then HALT command with HALT_WORD same cycle -> DRAIN taken, not IDLE.
REQ-046 i_rst low mid-DRAIN between clock edges -> all outputs 0 immediately, o_cycle_cnt=0, IDLE after release.
